// File: rtl/valu_op_sequencer_if.sv
// valu_op_sequencer_if
//   Groups the three buses around the vector-ALU issue/capture controller:
//   - request channel from decode (req_valid/req_ready handshake plus op fields)
//   - ALU drive/return bus (valu_s/t/fs/splat out, valu_y_hi/lo back)
//   - response channel to writeback (rsp_valid/rsp_ready handshake plus result)
//   Modports:
//   - slave  : the sequencer's view (consumes requests, drives ALU and responses)
//   - master : the surrounding pipeline/ALU view
interface valu_op_sequencer_if #(
  parameter int TAG_W = 4
) ();
  // Request channel
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_fs;
  logic [31:0]      req_s;
  logic [31:0]      req_t;
  logic [1:0]       req_splat;
  logic [TAG_W-1:0] req_tag;
  // ALU bus
  logic [31:0]      valu_s;
  logic [31:0]      valu_t;
  logic [4:0]       valu_fs;
  logic [1:0]       valu_splat;
  logic [31:0]      valu_y_hi;
  logic [31:0]      valu_y_lo;
  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_hi;
  logic [31:0]      rsp_lo;
  logic             rsp_hi_we;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dz;

  modport slave (
    input  req_valid, req_fs, req_s, req_t, req_splat, req_tag,
    output req_ready,
    output valu_s, valu_t, valu_fs, valu_splat,
    input  valu_y_hi, valu_y_lo,
    output rsp_valid, rsp_hi, rsp_lo, rsp_hi_we, rsp_tag, rsp_dz,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_fs, req_s, req_t, req_splat, req_tag,
    input  req_ready,
    input  valu_s, valu_t, valu_fs, valu_splat,
    output valu_y_hi, valu_y_lo,
    input  rsp_valid, rsp_hi, rsp_lo, rsp_hi_we, rsp_tag, rsp_dz,
    output rsp_ready
  );
endinterface

// File: rtl/valu_op_sequencer.sv
// valu_op_sequencer
//   Issue/capture controller in front of the combinational vector ALU.
//   Accepts one op at a time, holds the ALU inputs stable from registers for
//   SETTLE_CYC cycles, captures VY_hi/VY_lo, and presents the tagged result
//   (plus HI write-enable and divide-by-zero flag) to writeback.
//   Ports:
//   - clk    : system clock, rising edge
//   - rst    : asynchronous active-high reset
//   - bus_io : request / ALU / response buses (slave modport)
//   - busy_o : high whenever the controller is not idle
module valu_op_sequencer #(
  parameter int SETTLE_CYC = 2,
  parameter int TAG_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  valu_op_sequencer_if.slave bus_io,
  output logic               busy_o
);

  localparam int CNT_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE_WAIT = 2'd1,
    DONE       = 2'd2
  } state_t;

  // True when any of the four byte lanes is zero (vector divide-by-zero test).
  function automatic logic any_zero_byte(input logic [31:0] v);
    return (v[7:0] == 8'h00) | (v[15:8] == 8'h00) |
           (v[23:16] == 8'h00) | (v[31:24] == 8'h00);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      valu_s_q, valu_s_d;
  logic [31:0]      valu_t_q, valu_t_d;
  logic [4:0]       valu_fs_q, valu_fs_d;
  logic [1:0]       valu_splat_q, valu_splat_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_hi_q, rsp_hi_d;
  logic [31:0]      rsp_lo_q, rsp_lo_d;
  logic             rsp_hi_we_q, rsp_hi_we_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_dz_q, rsp_dz_d;
  logic             busy_q, busy_d;
  logic             req_ready_s;
  logic             accept_s;

  // Next-state, handshake and datapath-load logic.
  always_comb begin
    // A new op may only be taken when idle, or in DONE when writeback is
    // consuming the current result on this same cycle.
    req_ready_s = (state_q == IDLE) | ((state_q == DONE) & bus_io.rsp_ready);
    accept_s    = bus_io.req_valid & req_ready_s;

    // ALU inputs and tag change only on an accept edge; otherwise held.
    valu_s_d     = accept_s ? bus_io.req_s     : valu_s_q;
    valu_t_d     = accept_s ? bus_io.req_t     : valu_t_q;
    valu_fs_d    = accept_s ? bus_io.req_fs    : valu_fs_q;
    valu_splat_d = accept_s ? bus_io.req_splat : valu_splat_q;
    tag_d        = accept_s ? bus_io.req_tag   : tag_q;
    cnt_d        = accept_s ? CNT_LOAD         : cnt_q;

    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_hi_d    = rsp_hi_q;
    rsp_lo_d    = rsp_lo_q;
    rsp_hi_we_d = rsp_hi_we_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_dz_d    = rsp_dz_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = ISSUE_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE_WAIT: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          // Settle window elapsed: capture the ALU result and flags derived
          // from the held inputs, not from the (possibly changing) request bus.
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_hi_d    = bus_io.valu_y_hi;
          rsp_lo_d    = bus_io.valu_y_lo;
          rsp_tag_d   = tag_q;
          rsp_hi_we_d = (valu_fs_q == 5'h02) | (valu_fs_q == 5'h03);
          rsp_dz_d    = (valu_fs_q == 5'h03) & any_zero_byte(valu_t_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus_io.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (accept_s) begin
            state_d = ISSUE_WAIT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      valu_s_q     <= 32'h0000_0000;
      valu_t_q     <= 32'h0000_0000;
      valu_fs_q    <= 5'h00;
      valu_splat_q <= 2'b00;
      tag_q        <= {TAG_W{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_hi_q     <= 32'h0000_0000;
      rsp_lo_q     <= 32'h0000_0000;
      rsp_hi_we_q  <= 1'b0;
      rsp_tag_q    <= {TAG_W{1'b0}};
      rsp_dz_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valu_s_q     <= valu_s_d;
      valu_t_q     <= valu_t_d;
      valu_fs_q    <= valu_fs_d;
      valu_splat_q <= valu_splat_d;
      tag_q        <= tag_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hi_q     <= rsp_hi_d;
      rsp_lo_q     <= rsp_lo_d;
      rsp_hi_we_q  <= rsp_hi_we_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_dz_q     <= rsp_dz_d;
      busy_q       <= busy_d;
    end
  end

  assign bus_io.req_ready  = req_ready_s;
  assign bus_io.valu_s     = valu_s_q;
  assign bus_io.valu_t     = valu_t_q;
  assign bus_io.valu_fs    = valu_fs_q;
  assign bus_io.valu_splat = valu_splat_q;
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_hi     = rsp_hi_q;
  assign bus_io.rsp_lo     = rsp_lo_q;
  assign bus_io.rsp_hi_we  = rsp_hi_we_q;
  assign bus_io.rsp_tag    = rsp_tag_q;
  assign bus_io.rsp_dz     = rsp_dz_q;
  assign busy_o            = busy_q;

endmodule
